// File: rtl/bus_cycle_ctrl.sv
// 8086-style bus cycle sequencer: T1-T2-T3-(Tw)-T4 cycles on an 8-bit bus,
// prefetching code bytes into the instruction queue, with data requests taking priority.
module bus_cycle_ctrl #(
  parameter int QUEUE_DEPTH = 4,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Fetch_Addr,
  input  logic [2:0]        Q_Count,
  input  logic              Q_Flush,
  input  logic              Data_Req,
  input  logic              Data_WR,
  input  logic [ADDR_W-1:0] Data_Addr,
  input  logic [DATA_W-1:0] Data_Out,
  output logic              Data_Ack,
  output logic [DATA_W-1:0] Data_In,
  input  logic              Ready,
  input  logic [DATA_W-1:0] Bus_In,
  output logic [DATA_W-1:0] Bus_Out,
  output logic              Bus_OE,
  output logic [ADDR_W-1:0] Addr,
  output logic              ALE,
  output logic              RD_n,
  output logic              WR_n,
  output logic              Q_Push,
  output logic [DATA_W-1:0] Q_Byte,
  output logic              IP_Inc,
  output logic              Busy
);

  typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} state_t;

  localparam logic [3:0] DEPTH = 4'(QUEUE_DEPTH);

  state_t     state, state_nxt;
  logic       cyc_data, cyc_wr, flush_pend;
  logic       deliver, grant_data, grant_fetch, launch, strobe;
  logic [3:0] eff_cnt;

  // The byte being pushed this T4 still counts against queue space for the next grant.
  always_comb begin
    deliver     = (state == T4) && !cyc_data && !flush_pend && !Q_Flush;
    eff_cnt     = {1'b0, Q_Count} + (deliver ? 4'd1 : 4'd0);
    grant_data  = Data_Req && !((state == T4) && cyc_data);
    grant_fetch = !Q_Flush && (eff_cnt < DEPTH);
    launch      = 1'b0;
    state_nxt   = state;
    case (state)
      IDLE, T4: begin
        if (grant_data || grant_fetch) begin
          state_nxt = T1;
          launch    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      T1:      state_nxt = T2;
      T2:      state_nxt = T3;
      T3, TW:  state_nxt = Ready ? T4 : TW;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    strobe   = (state == T2) || (state == T3) || (state == TW);
    ALE      = (state == T1);
    RD_n     = !(strobe && !cyc_wr);
    WR_n     = !(strobe && cyc_wr);
    Bus_OE   = cyc_wr && (strobe || (state == T4));
    Q_Push   = deliver;
    IP_Inc   = deliver;
    Data_Ack = (state == T4) && cyc_data;
    Busy     = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cyc_data   <= 1'b0;
      cyc_wr     <= 1'b0;
      flush_pend <= 1'b0;
      Addr       <= '0;
      Bus_Out    <= '0;
      Data_In    <= '0;
      Q_Byte     <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        cyc_data <= grant_data;
        cyc_wr   <= grant_data && Data_WR;
        Addr     <= grant_data ? Data_Addr : Fetch_Addr;
        if (grant_data && Data_WR)
          Bus_Out <= Data_Out;
      end
      // Read data is taken on the edge that leaves T3/TW with memory ready.
      if ((state == T3 || state == TW) && Ready && !cyc_wr) begin
        if (cyc_data)
          Data_In <= Bus_In;
        else
          Q_Byte <= Bus_In;
      end
      if (state == T4)
        flush_pend <= 1'b0;
      else if (!cyc_data && Q_Flush && (state == T1 || strobe))
        flush_pend <= 1'b1;
    end
  end

endmodule
